// File: rtl/host_bus_interface.sv
// Host bus bridge: brings the asynchronous System 573 host strobes into the clock domain
// and turns each host access into one single-cycle register read or write request.
`timescale 1ns / 1ps

module host_bus_interface #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  nReset,
   input  logic [ADDR_WIDTH-1:0] hostAddress,
   input  logic                  hostNCS,
   input  logic                  hostNRD,
   input  logic                  hostNWR,
   input  logic [DATA_WIDTH-1:0] hostDataIn,
   output logic [DATA_WIDTH-1:0] hostDataOut,
   output logic                  hostDataOE,
   output logic [ADDR_WIDTH-1:0] regAddress,
   output logic [DATA_WIDTH-1:0] regWriteData,
   output logic                  regWrite,
   output logic                  regRead,
   input  logic [DATA_WIDTH-1:0] regReadData
);

   typedef enum logic [1:0] {
      IDLE,
      READ_LATCH,
      READ_DRIVE,
      WAIT_RELEASE
   } state_t;

   state_t                  state_q, state_d;
   logic [1:0]              csSync_q, rdSync_q, wrSync_q;
   logic [ADDR_WIDTH-1:0]   regAddress_q, regAddress_d;
   logic [DATA_WIDTH-1:0]   regWriteData_q, regWriteData_d;
   logic [DATA_WIDTH-1:0]   hostDataOut_q, hostDataOut_d;
   logic                    hostDataOE_q, hostDataOE_d;
   logic                    regRead_q, regRead_d;
   logic                    regWrite_q, regWrite_d;
   logic                    sCS, sRD, sWR;

   // Two-stage synchronisers idle high so reset looks like "no access in progress".
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         csSync_q <= 2'b11;
         rdSync_q <= 2'b11;
         wrSync_q <= 2'b11;
      end else begin
         csSync_q <= {csSync_q[0], hostNCS};
         rdSync_q <= {rdSync_q[0], hostNRD};
         wrSync_q <= {wrSync_q[0], hostNWR};
      end
   end

   assign sCS = ~csSync_q[1];
   assign sRD = ~rdSync_q[1];
   assign sWR = ~wrSync_q[1];

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state_q        <= IDLE;
         regAddress_q   <= '0;
         regWriteData_q <= '0;
         hostDataOut_q  <= '0;
         hostDataOE_q   <= 1'b0;
         regRead_q      <= 1'b0;
         regWrite_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         regAddress_q   <= regAddress_d;
         regWriteData_q <= regWriteData_d;
         hostDataOut_q  <= hostDataOut_d;
         hostDataOE_q   <= hostDataOE_d;
         regRead_q      <= regRead_d;
         regWrite_q     <= regWrite_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      regAddress_d   = regAddress_q;
      regWriteData_d = regWriteData_q;
      hostDataOut_d  = hostDataOut_q;
      hostDataOE_d   = 1'b0;
      regRead_d      = 1'b0;
      regWrite_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sCS && sRD && !sWR) begin
               regAddress_d = hostAddress;
               regRead_d    = 1'b1;
               state_d      = READ_LATCH;
            end else if (sCS && sWR && !sRD) begin
               regAddress_d   = hostAddress;
               regWriteData_d = hostDataIn;
               regWrite_d     = 1'b1;
               state_d        = WAIT_RELEASE;
            end else if (sCS && sRD && sWR) begin
               state_d = WAIT_RELEASE;
            end
         end
         // regReadData is sampled here while regRead is still high.
         READ_LATCH: begin
            hostDataOut_d = regReadData;
            if (!sCS || !sRD) begin
               state_d = WAIT_RELEASE;
            end else begin
               hostDataOE_d = 1'b1;
               state_d      = READ_DRIVE;
            end
         end
         // A clean release skips the WAIT_RELEASE cycle since its exit condition already holds.
         READ_DRIVE: begin
            if (!sCS || !sRD) begin
               state_d = (!sRD && !sWR) ? IDLE : WAIT_RELEASE;
            end else begin
               hostDataOE_d = 1'b1;
            end
         end
         WAIT_RELEASE: begin
            if (!sRD && !sWR) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign hostDataOut  = hostDataOut_q;
   assign hostDataOE   = hostDataOE_q;
   assign regAddress   = regAddress_q;
   assign regWriteData = regWriteData_q;
   assign regRead      = regRead_q;
   assign regWrite     = regWrite_q;

endmodule

// File: tb/tb_host_bus_interface.sv
// Directed bench for host_bus_interface: table of complete host accesses plus
// hand-written sequences for cycle timing, aborted reads, back-to-back and reset.
`timescale 1ns / 1ps

module tb_host_bus_interface;

   localparam int AW = 6;
   localparam int DW = 16;

   logic          clock = 1'b0;
   logic          nReset;
   logic [AW-1:0] hostAddress;
   logic          hostNCS, hostNRD, hostNWR;
   logic [DW-1:0] hostDataIn;
   logic [DW-1:0] hostDataOut;
   logic          hostDataOE;
   logic [AW-1:0] regAddress;
   logic [DW-1:0] regWriteData;
   logic          regWrite, regRead;
   logic [DW-1:0] regReadData;
   logic [DW-1:0] readValue;

   int checks = 0;
   int errors = 0;
   int readPulses = 0, writePulses = 0, oeCycles = 0, longPulses = 0;
   int cycleCount = 0, lastReadCycle = 0, lastWriteCycle = 0;
   logic prevRead = 1'b0, prevWrite = 1'b0;

   typedef struct {
      logic          isRead;
      logic          isWrite;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [DW-1:0] readVal;
      int            hold;
      logic [AW-1:0] expAddr;
      logic [DW-1:0] expWData;
      logic [DW-1:0] expOut;
      int            expW;
      int            expR;
      int            expOe;
   } vector_t;

   vector_t vectors[6];

   host_bus_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clock       (clock),
      .nReset      (nReset),
      .hostAddress (hostAddress),
      .hostNCS     (hostNCS),
      .hostNRD     (hostNRD),
      .hostNWR     (hostNWR),
      .hostDataIn  (hostDataIn),
      .hostDataOut (hostDataOut),
      .hostDataOE  (hostDataOE),
      .regAddress  (regAddress),
      .regWriteData(regWriteData),
      .regWrite    (regWrite),
      .regRead     (regRead),
      .regReadData (regReadData)
   );

   always #5 clock = ~clock;

   // The register file only presents valid data while regRead is high.
   assign regReadData = regRead ? readValue : 16'hDEAD;

   // Count pulses and OE cycles mid-cycle, away from the rising edge.
   always @(negedge clock) begin
      cycleCount++;
      if (regRead) begin
         readPulses++;
         lastReadCycle = cycleCount;
      end
      if (regWrite) begin
         writePulses++;
         lastWriteCycle = cycleCount;
      end
      if (hostDataOE) oeCycles++;
      if ((regRead && prevRead) || (regWrite && prevWrite) || (regRead && regWrite)) longPulses++;
      prevRead  = regRead;
      prevWrite = regWrite;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic releaseBus();
      hostNCS = 1'b1;
      hostNRD = 1'b1;
      hostNWR = 1'b1;
   endtask

   // One complete host access: strobes low for 'hold' edges, then released and settled.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data, input logic [DW-1:0] rv, input int hold);
      @(posedge clock);
      #1;
      hostAddress = addr;
      hostDataIn  = data;
      readValue   = rv;
      hostNCS     = 1'b0;
      hostNRD     = ~rd;
      hostNWR     = ~wr;
      repeat (hold) @(posedge clock);
      #1;
      releaseBus();
      repeat (4) @(posedge clock);
      #1;
   endtask

   initial begin
      int r0, w0, o0, l0;

      vectors[0] = '{1'b0, 1'b1, 6'h15, 16'hBEEF, 16'h0000,  6, 6'h15, 16'hBEEF, 16'h0000, 1, 0,  0};
      vectors[1] = '{1'b1, 1'b0, 6'h03, 16'h0000, 16'h1234,  8, 6'h03, 16'hBEEF, 16'h1234, 0, 1,  7};
      vectors[2] = '{1'b0, 1'b1, 6'h0C, 16'h1357, 16'h0000, 20, 6'h0C, 16'h1357, 16'h1234, 1, 0,  0};
      vectors[3] = '{1'b1, 1'b0, 6'h2A, 16'h0000, 16'hA5C3, 20, 6'h2A, 16'h1357, 16'hA5C3, 0, 1, 19};
      vectors[4] = '{1'b1, 1'b1, 6'h3F, 16'hFFFF, 16'h0000,  5, 6'h2A, 16'h1357, 16'hA5C3, 0, 0,  0};
      vectors[5] = '{1'b0, 1'b1, 6'h01, 16'h00FF, 16'h0000,  4, 6'h01, 16'h00FF, 16'hA5C3, 1, 0,  0};

      nReset      = 1'b0;
      hostAddress = '0;
      hostDataIn  = '0;
      readValue   = '0;
      releaseBus();
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset_dataOut",   32'(hostDataOut),  32'h0);
      checkOutput("reset_oe",        32'(hostDataOE),   32'h0);
      checkOutput("reset_addr",      32'(regAddress),   32'h0);
      checkOutput("reset_wdata",     32'(regWriteData), 32'h0);
      checkOutput("reset_write",     32'(regWrite),     32'h0);
      checkOutput("reset_read",      32'(regRead),      32'h0);
      nReset = 1'b1;
      repeat (2) @(posedge clock);

      for (int i = 0; i < 6; i++) begin
         r0 = readPulses; w0 = writePulses; o0 = oeCycles; l0 = longPulses;
         applyStimulus(vectors[i].isRead, vectors[i].isWrite, vectors[i].addr,
                       vectors[i].data, vectors[i].readVal, vectors[i].hold);
         checkOutput($sformatf("vec%0d_addr", i),    32'(regAddress),   32'(vectors[i].expAddr));
         checkOutput($sformatf("vec%0d_wdata", i),   32'(regWriteData), 32'(vectors[i].expWData));
         checkOutput($sformatf("vec%0d_dataOut", i), 32'(hostDataOut),  32'(vectors[i].expOut));
         checkOutput($sformatf("vec%0d_writes", i),  32'(writePulses - w0), 32'(vectors[i].expW));
         checkOutput($sformatf("vec%0d_reads", i),   32'(readPulses - r0),  32'(vectors[i].expR));
         checkOutput($sformatf("vec%0d_oeCycles", i), 32'(oeCycles - o0),   32'(vectors[i].expOe));
         checkOutput($sformatf("vec%0d_longPulse", i), 32'(longPulses - l0), 32'h0);
      end

      // Read cycle timing: request at edge 3, data and OE at edge 4, OE drops after r+2.
      @(posedge clock);
      #1;
      hostAddress = 6'h07;
      readValue   = 16'hCAFE;
      hostNCS     = 1'b0;
      hostNRD     = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("rd_t2_read", 32'(regRead), 32'h0);
      @(posedge clock);
      #1;
      checkOutput("rd_t3_read", 32'(regRead), 32'h1);
      checkOutput("rd_t3_addr", 32'(regAddress), 32'h07);
      checkOutput("rd_t3_oe",   32'(hostDataOE), 32'h0);
      @(posedge clock);
      #1;
      checkOutput("rd_t4_read",    32'(regRead), 32'h0);
      checkOutput("rd_t4_oe",      32'(hostDataOE), 32'h1);
      checkOutput("rd_t4_dataOut", 32'(hostDataOut), 32'hCAFE);
      repeat (4) @(posedge clock);
      #1;
      releaseBus();
      repeat (2) @(posedge clock);
      #1;
      checkOutput("rd_r1_oe", 32'(hostDataOE), 32'h1);
      @(posedge clock);
      #1;
      checkOutput("rd_r2_oe", 32'(hostDataOE), 32'h0);
      repeat (2) @(posedge clock);

      // Aborted read: CS and NRD low for a single edge only.
      r0 = readPulses; o0 = oeCycles;
      @(posedge clock);
      #1;
      hostAddress = 6'h2E;
      readValue   = 16'h0BAD;
      hostNCS     = 1'b0;
      hostNRD     = 1'b0;
      @(posedge clock);
      #1;
      releaseBus();
      repeat (6) @(posedge clock);
      #1;
      checkOutput("abort_readsAtMostOne", 32'((readPulses - r0) <= 1), 32'h1);
      checkOutput("abort_oeCycles", 32'(oeCycles - o0), 32'h0);
      w0 = writePulses;
      applyStimulus(1'b0, 1'b1, 6'h22, 16'h4321, 16'h0000, 4);
      checkOutput("abort_nextWrite", 32'(writePulses - w0), 32'h1);
      checkOutput("abort_nextWdata", 32'(regWriteData), 32'h4321);
      checkOutput("abort_nextAddr",  32'(regAddress),   32'h22);

      // Back-to-back: write, two high cycles, then read.
      r0 = readPulses; w0 = writePulses;
      @(posedge clock);
      #1;
      hostAddress = 6'h0A;
      hostDataIn  = 16'h5555;
      hostNCS     = 1'b0;
      hostNWR     = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("b2b_t2_write", 32'(regWrite), 32'h0);
      @(posedge clock);
      #1;
      checkOutput("b2b_t3_write", 32'(regWrite), 32'h1);
      checkOutput("b2b_t3_wdata", 32'(regWriteData), 32'h5555);
      @(posedge clock);
      #1;
      checkOutput("b2b_t4_write", 32'(regWrite), 32'h0);
      releaseBus();
      repeat (2) @(posedge clock);
      #1;
      hostAddress = 6'h0B;
      readValue   = 16'h6B6B;
      hostNCS     = 1'b0;
      hostNRD     = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      releaseBus();
      repeat (4) @(posedge clock);
      #1;
      checkOutput("b2b_writes",  32'(writePulses - w0), 32'h1);
      checkOutput("b2b_reads",   32'(readPulses - r0),  32'h1);
      checkOutput("b2b_order",   32'(lastWriteCycle < lastReadCycle), 32'h1);
      checkOutput("b2b_addr",    32'(regAddress),   32'h0B);
      checkOutput("b2b_wdata",   32'(regWriteData), 32'h5555);
      checkOutput("b2b_dataOut", 32'(hostDataOut),  32'h6B6B);

      // Reset asserted while the read data is being driven.
      @(posedge clock);
      #1;
      hostAddress = 6'h3C;
      readValue   = 16'h7777;
      hostNCS     = 1'b0;
      hostNRD     = 1'b0;
      repeat (6) @(posedge clock);
      #3;
      checkOutput("rst_pre_oe", 32'(hostDataOE), 32'h1);
      nReset = 1'b0;
      #1;
      checkOutput("rst_oe",      32'(hostDataOE),  32'h0);
      checkOutput("rst_dataOut", 32'(hostDataOut), 32'h0);
      checkOutput("rst_addr",    32'(regAddress),  32'h0);
      checkOutput("rst_read",    32'(regRead),     32'h0);
      releaseBus();
      repeat (3) @(posedge clock);
      #1;
      nReset = 1'b1;
      r0 = readPulses; w0 = writePulses; o0 = oeCycles;
      repeat (8) @(posedge clock);
      #1;
      checkOutput("rst_after_reads",  32'(readPulses - r0),  32'h0);
      checkOutput("rst_after_writes", 32'(writePulses - w0), 32'h0);
      checkOutput("rst_after_oe",     32'(oeCycles - o0),    32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
